alu_seq: RTL and testbench

// Registered, handshaked successor to the combinational ALU. Accepts one operation per
// in_valid/in_ready transfer and returns a registered result on out_valid/out_ready.

---
 rtl/alu_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops, 1-bit/cycle rotates, 1-step/cycle shift-add multiply.
// Latency 1, k+1 or BUS_WIDTH+1 edges; accepts only in IDLE, result holds in DONE until out_ready.
module alu_seq #(
   parameter int BUS_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           opcode,
   input  logic [BUS_WIDTH-1:0] a,
   input  logic [BUS_WIDTH-1:0] b,
   input  logic                 carry_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BUS_WIDTH-1:0] y,
   output logic [BUS_WIDTH-1:0] y_hi,
   output logic                 carry_out,
   output logic                 borrow,
   output logic                 zero,
   output logic                 parity,
   output logic                 invalid_op
);
   localparam int W  = BUS_WIDTH;
   localparam int S  = $clog2(BUS_WIDTH);
   localparam int CW = S + 1;

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_ADDC = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_INC  = 4'd4;
   localparam logic [3:0] OP_DEC  = 4'd5;
   localparam logic [3:0] OP_AND  = 4'd6;
   localparam logic [3:0] OP_NOT  = 4'd7;
   localparam logic [3:0] OP_ROL  = 4'd8;
   localparam logic [3:0] OP_ROR  = 4'd9;
   localparam logic [3:0] OP_OR   = 4'd10;
   localparam logic [3:0] OP_XOR  = 4'd11;
   localparam logic [3:0] OP_MUL  = 4'd12;

   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MUL = CW'(W);
   localparam logic [W:0]    ONE_W1  = (W+1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     op_q, op_d;
   logic [W-1:0]   mcand_q, mcand_d;
   logic [2*W-1:0] work_q, work_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   y_q, y_d;
   logic [W-1:0]   y_hi_q, y_hi_d;
   logic           carry_q, carry_d;
   logic           borrow_q, borrow_d;
   logic           zero_q, zero_d;
   logic           parity_q, parity_d;
   logic           inv_q, inv_d;

   logic [S-1:0]   amt;
   logic [W-1:0]   sc_y;
   logic           sc_c, sc_bw, sc_inv;
   logic [W-1:0]   rol_nxt, ror_nxt;
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_nxt;
   logic           load;
   logic [W-1:0]   ld_y, ld_hi;
   logic           ld_c, ld_bw, ld_inv;

   assign amt     = b[S-1:0];
   assign rol_nxt = {work_q[W-2:0], work_q[W-1]};
   assign ror_nxt = {work_q[0], work_q[W-1:1]};
   // Product register starts as {0, multiplier}; each step adds the multiplicand
   // into the high half when the current LSB is set, then shifts right by one.
   assign mul_sum = {1'b0, work_q[2*W-1:W]} + {1'b0, mcand_q & {W{work_q[0]}}};
   assign mul_nxt = {mul_sum, work_q[W-1:1]};

   always_comb begin
      sc_y   = '0;
      sc_c   = 1'b0;
      sc_bw  = 1'b0;
      sc_inv = 1'b0;
      case (opcode)
         OP_ADD:  sc_y = a + b;
         OP_ADDC: {sc_c, sc_y} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
         OP_SUB:  {sc_bw, sc_y} = {1'b0, a} - {1'b0, b};
         OP_INC:  {sc_c, sc_y} = {1'b0, a} + ONE_W1;
         OP_DEC:  {sc_bw, sc_y} = {1'b0, a} - ONE_W1;
         OP_AND:  sc_y = a & b;
         OP_NOT:  sc_y = ~a;
         OP_ROL,
         OP_ROR:  sc_y = a;
         OP_OR:   sc_y = a | b;
         OP_XOR:  sc_y = a ^ b;
         OP_MUL:  sc_y = '0;
         default: sc_inv = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      mcand_d  = mcand_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      y_d      = y_q;
      y_hi_d   = y_hi_q;
      carry_d  = carry_q;
      borrow_d = borrow_q;
      zero_d   = zero_q;
      parity_d = parity_q;
      inv_d    = inv_q;
      load     = 1'b0;
      ld_y     = '0;
      ld_hi    = '0;
      ld_c     = 1'b0;
      ld_bw    = 1'b0;
      ld_inv   = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = opcode;
               mcand_d = a;
               if (opcode == OP_MUL) begin
                  work_d  = {{W{1'b0}}, b};
                  cnt_d   = CNT_MUL;
                  state_d = BUSY;
               end else if ((opcode == OP_ROL || opcode == OP_ROR) && amt != '0) begin
                  work_d  = {{W{1'b0}}, a};
                  cnt_d   = {{(CW-S){1'b0}}, amt};
                  state_d = BUSY;
               end else begin
                  load    = 1'b1;
                  ld_y    = sc_y;
                  ld_c    = sc_c;
                  ld_bw   = sc_bw;
                  ld_inv  = sc_inv;
                  state_d = DONE;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_ONE;
            if (op_q == OP_MUL) begin
               work_d = mul_nxt;
            end else if (op_q == OP_ROL) begin
               work_d = {{W{1'b0}}, rol_nxt};
            end else begin
               work_d = {{W{1'b0}}, ror_nxt};
            end
            if (cnt_q == CNT_ONE) begin
               load    = 1'b1;
               ld_y    = work_d[W-1:0];
               ld_hi   = work_d[2*W-1:W];
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Output registers only change on completion, so they stay stable under backpressure.
      if (load) begin
         y_d      = ld_y;
         y_hi_d   = ld_hi;
         carry_d  = ld_c;
         borrow_d = ld_bw;
         inv_d    = ld_inv;
         zero_d   = ({ld_hi, ld_y} == '0);
         parity_d = ^ld_y;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         mcand_q  <= '0;
         work_q   <= '0;
         cnt_q    <= '0;
         y_q      <= '0;
         y_hi_q   <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
         parity_q <= 1'b0;
         inv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         mcand_q  <= mcand_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         y_q      <= y_d;
         y_hi_q   <= y_hi_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
         zero_q   <= zero_d;
         parity_q <= parity_d;
         inv_q    <= inv_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign y          = y_q;
   assign y_hi       = y_hi_q;
   assign carry_out  = carry_q;
   assign borrow     = borrow_q;
   assign zero       = zero_q;
   assign parity     = parity_q;
   assign invalid_op = inv_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (BUS_WIDTH=8) with hand-computed expected results.
`timescale 1ns/1ps
module tb_alu_seq;
   localparam int W = 8;

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_ADDC = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_INC  = 4'd4;
   localparam logic [3:0] OP_DEC  = 4'd5;
   localparam logic [3:0] OP_AND  = 4'd6;
   localparam logic [3:0] OP_NOT  = 4'd7;
   localparam logic [3:0] OP_ROL  = 4'd8;
   localparam logic [3:0] OP_ROR  = 4'd9;
   localparam logic [3:0] OP_OR   = 4'd10;
   localparam logic [3:0] OP_XOR  = 4'd11;
   localparam logic [3:0] OP_MUL  = 4'd12;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   opcode;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         carry_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y;
   logic [W-1:0] y_hi;
   logic         carry_out;
   logic         borrow;
   logic         zero;
   logic         parity;
   logic         invalid_op;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_seq #(.BUS_WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .y_hi      (y_hi),
      .carry_out (carry_out),
      .borrow    (borrow),
      .zero      (zero),
      .parity    (parity),
      .invalid_op(invalid_op)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, measure edges to out_valid, check all outputs, then consume.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] av,
                         input logic [7:0] bv, input logic ci, input int exp_lat,
                         input logic [7:0] ey, input logic [7:0] ehi, input logic ec,
                         input logic ebw, input logic ez, input logic ep, input logic einv);
      int lat;
      check({tag, ":in_ready"}, 16'(in_ready), 16'h1);
      opcode = op; a = av; b = bv; carry_in = ci; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; opcode = OP_SUB; a = ~av; b = ~bv; carry_in = ~ci;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ":latency"}, 16'(lat), 16'(exp_lat));
      check({tag, ":y"}, 16'(y), 16'(ey));
      check({tag, ":y_hi"}, 16'(y_hi), 16'(ehi));
      check({tag, ":c/bw/z/p/inv"}, 16'({carry_out, borrow, zero, parity, invalid_op}),
            16'({ec, ebw, ez, ep, einv}));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ":back_to_idle"}, 16'({in_ready, out_valid}), 16'b10);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; opcode = '0; a = '0; b = '0;
      carry_in = 1'b0; out_ready = 1'b0;
      #12;
      check("reset:rdy/vld", 16'({in_ready, out_valid}), 16'b10);
      check("reset:y", 16'({y_hi, y}), 16'h0000);
      check("reset:flags", 16'({carry_out, borrow, zero, parity, invalid_op}), 16'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      //            tag        op       a      b      ci lat y      hi     c  bw z  p  inv
      run_op("add",      OP_ADD,  8'h03, 8'h04, 0, 1, 8'h07, 8'h00, 0, 0, 0, 1, 0);

      // Reset while MUL is in BUSY: outputs must clear immediately.
      opcode = OP_MUL; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mul_busy:rdy/vld", 16'({in_ready, out_valid}), 16'b00);
      rst_n = 1'b0;
      #1;
      check("rst_mid:rdy/vld", 16'({in_ready, out_valid}), 16'b10);
      check("rst_mid:y", 16'({y_hi, y}), 16'h0000);
      check("rst_mid:flags", 16'({carry_out, borrow, zero, parity, invalid_op}), 16'h0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("addc",     OP_ADDC, 8'hFF, 8'h00, 1, 1, 8'h00, 8'h00, 1, 0, 1, 0, 0);
      run_op("add_wrap", OP_ADD,  8'hFF, 8'h01, 0, 1, 8'h00, 8'h00, 0, 0, 1, 0, 0);
      run_op("sub_bw",   OP_SUB,  8'h03, 8'h05, 0, 1, 8'hFE, 8'h00, 0, 1, 0, 1, 0);
      run_op("sub",      OP_SUB,  8'h05, 8'h03, 0, 1, 8'h02, 8'h00, 0, 0, 0, 1, 0);
      run_op("inc",      OP_INC,  8'hFF, 8'h00, 0, 1, 8'h00, 8'h00, 1, 0, 1, 0, 0);
      run_op("dec",      OP_DEC,  8'h00, 8'h00, 0, 1, 8'hFF, 8'h00, 0, 1, 0, 0, 0);
      run_op("and",      OP_AND,  8'hF0, 8'h3C, 0, 1, 8'h30, 8'h00, 0, 0, 0, 0, 0);
      run_op("not",      OP_NOT,  8'h5A, 8'h00, 0, 1, 8'hA5, 8'h00, 0, 0, 0, 0, 0);
      run_op("or",       OP_OR,   8'hF0, 8'h0F, 0, 1, 8'hFF, 8'h00, 0, 0, 0, 0, 0);
      run_op("rol3",     OP_ROL,  8'h81, 8'h03, 0, 4, 8'h0C, 8'h00, 0, 0, 0, 0, 0);
      run_op("ror0",     OP_ROR,  8'h81, 8'h00, 0, 1, 8'h81, 8'h00, 0, 0, 0, 0, 0);
      run_op("ror1_hib", OP_ROR,  8'h81, 8'h09, 0, 2, 8'hC0, 8'h00, 0, 0, 0, 0, 0);
      run_op("rol7",     OP_ROL,  8'h81, 8'h07, 0, 8, 8'hC0, 8'h00, 0, 0, 0, 0, 0);
      run_op("mul10",    OP_MUL,  8'h10, 8'h10, 0, 9, 8'h00, 8'h01, 0, 0, 0, 0, 0);
      run_op("mul0",     OP_MUL,  8'h00, 8'hFF, 0, 9, 8'h00, 8'h00, 0, 0, 1, 0, 0);
      run_op("mulFF",    OP_MUL,  8'hFF, 8'hFF, 0, 9, 8'h01, 8'hFE, 0, 0, 0, 1, 0);
      run_op("add_hi0",  OP_ADD,  8'h03, 8'h04, 0, 1, 8'h07, 8'h00, 0, 0, 0, 1, 0);
      run_op("inv14",    4'd14,   8'hFF, 8'hFF, 1, 1, 8'h00, 8'h00, 0, 0, 1, 0, 1);
      run_op("inv0",     4'd0,    8'h5A, 8'h11, 1, 1, 8'h00, 8'h00, 0, 0, 1, 0, 1);

      // Backpressure: XOR result held for 5 cycles while a competing op is offered.
      check("bp:in_ready", 16'(in_ready), 16'h1);
      opcode = OP_XOR; a = 8'hF0; b = 8'hFF; in_valid = 1'b1;
      @(posedge clk); #1;
      opcode = OP_ADD; a = 8'h01; b = 8'h01;
      for (int i = 0; i < 5; i++) begin
         check("bp:rdy/vld", 16'({in_ready, out_valid}), 16'b01);
         check("bp:y", 16'(y), 16'h000F);
         check("bp:flags", 16'({carry_out, borrow, zero, parity, invalid_op}), 16'h0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("bp:y_after", 16'(y), 16'h000F);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp:idle", 16'({in_ready, out_valid}), 16'b10);
      check("bp:y_kept", 16'(y), 16'h000F);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
